// File: rtl/counter_arbiter_if.sv
// Requester/counter bundle for counter_arbiter.
// The master side is the environment: the requesters and the shared counter.
// The slave side is the arbiter.
interface counter_arbiter_if #(
    parameter int WIDTH = 8
);
    // Requester side
    logic [1:0]       REQ;
    logic [WIDTH-1:0] START0;
    logic [WIDTH-1:0] START1;
    logic [WIDTH-1:0] LEN0;
    logic [WIDTH-1:0] LEN1;
    logic [1:0]       GNT;
    logic [1:0]       DONE;
    logic             BUSY;

    // Counter side
    logic             CNT_LOAD;
    logic [WIDTH-1:0] CNT_VALUE;
    logic [WIDTH-1:0] CNT_C;

    modport master (
        output REQ, START0, START1, LEN0, LEN1, CNT_C,
        input  GNT, DONE, BUSY, CNT_LOAD, CNT_VALUE
    );

    modport slave (
        input  REQ, START0, START1, LEN0, LEN1, CNT_C,
        output GNT, DONE, BUSY, CNT_LOAD, CNT_VALUE
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin scheduler that shares one loadable up-counter between two
// requesters. A grant loads the counter with the requester's start value.
// The window closes with a one-cycle DONE once the counter output reaches
// start+length, computed modulo 2^WIDTH.
module counter_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    counter_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    logic             ptr;      // requester favoured when both ask
    logic             owner;    // requester holding the current window
    logic [WIDTH-1:0] target;

    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_value;

    logic             pick;
    logic [WIDTH-1:0] start_sel;
    logic [WIDTH-1:0] target_next;

    // Choose the next owner and its window end from the current requests
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        pick        = 1'b0;
        start_sel   = bus.START0;
        target_next = bus.START0 + bus.LEN0;
        if (bus.REQ == 2'b11) begin
            pick = ptr;
        end else begin
            pick = bus.REQ[1];
        end
        if (pick) begin
            start_sel   = bus.START1;
            target_next = bus.START1 + bus.LEN1;   // carry discarded by width
        end
    end

    // Window FSM with all outputs registered; reset aborts any window at once
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            target    <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            cnt_load  <= 1'b0;
            cnt_value <= '0;
        end else begin
            // NOTE: state is written with non-blocking assignments so every
            // register updates from the values present before the edge.
            done <= '0;
            case (state)
                IDLE: begin
                    if (|bus.REQ) begin
                        gnt       <= pick ? 2'b10 : 2'b01;
                        owner     <= pick;
                        ptr       <= ~pick;
                        target    <= target_next;
                        cnt_load  <= 1'b1;
                        cnt_value <= start_sel;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Counter output is stale here; it takes the load at this edge.
                    cnt_load <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (bus.CNT_C == target) begin
                        gnt         <= '0;
                        done[owner] <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.GNT       = gnt;
    assign bus.DONE      = done;
    assign bus.BUSY      = busy;
    assign bus.CNT_LOAD  = cnt_load;
    assign bus.CNT_VALUE = cnt_value;

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter. It models the shared counter and
// queues the expected windows as requests are driven. A negedge monitor pops
// each window from the queue and checks it when the window completes.
module tb_counter_arbiter;

    localparam int WIDTH = 8;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] start;
        logic [WIDTH-1:0] len;
    } win_t;

    logic clk;
    logic reset;
    logic [WIDTH-1:0] cnt_c;

    counter_arbiter_if #(.WIDTH(WIDTH)) bus();

    counter_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    win_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   gnt_seen = 0;
    bit   in_window = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loadable up-counter shared by both requesters
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             cnt_c <= '0;
        else if (bus.CNT_LOAD) cnt_c <= bus.CNT_VALUE;
        else                   cnt_c <= cnt_c + 1'b1;
    end
    assign bus.CNT_C = cnt_c;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // Monitor: check grant, hold, and completion of each queued window
    initial begin
        logic [1:0]       prev_gnt = '0;
        logic [1:0]       prev_done = '0;
        logic [WIDTH-1:0] prev_c = '0;
        logic [WIDTH-1:0] tgt;
        int               cycles = 0;
        win_t             e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_window = 0;
                prev_gnt  = '0;
                prev_done = '0;
                prev_c    = '0;
            end else begin
                if (prev_done != 2'b00) check("done_width", 32'(bus.DONE), 32'(0));
                if (bus.DONE != 2'b00) begin
                    if (!in_window || exp_q.size() == 0) begin
                        check("spurious_done", 32'(bus.DONE), 32'(0));
                    end else begin
                        e   = exp_q.pop_front();
                        tgt = e.start + e.len;
                        check("done_id",    32'(bus.DONE), 32'(onehot(e.id)));
                        check("gnt_cycles", 32'(cycles),   32'(e.len) + 32'd2);
                        check("c_at_match", 32'(prev_c),   32'(tgt));
                        check("gnt_clear",  32'(bus.GNT),  32'(0));
                        check("busy_clear", 32'(bus.BUSY), 32'(0));
                        in_window = 0;
                    end
                end
                if (bus.GNT != 2'b00 && prev_gnt == 2'b00) begin
                    gnt_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_gnt", 32'(bus.GNT), 32'(0));
                    end else begin
                        e = exp_q[0];
                        check("gnt_id",    32'(bus.GNT),       32'(onehot(e.id)));
                        check("load_high", 32'(bus.CNT_LOAD),  32'(1));
                        check("load_val",  32'(bus.CNT_VALUE), 32'(e.start));
                        check("busy_set",  32'(bus.BUSY),      32'(1));
                        in_window = 1;
                        cycles    = 1;
                    end
                end else if (in_window) begin
                    cycles++;
                    e = exp_q[0];
                    check("gnt_hold",  32'(bus.GNT),  32'(onehot(e.id)));
                    check("busy_hold", 32'(bus.BUSY), 32'(1));
                    if (cycles == 2) check("load_drop", 32'(bus.CNT_LOAD), 32'(0));
                end
                prev_gnt  = bus.GNT;
                prev_done = bus.DONE;
                prev_c    = bus.CNT_C;
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !in_window) begin
                ok = 1;
                break;
            end
        end
        #1;
        check({"drain_", tag}, 32'(ok), 32'(1));
    endtask

    task automatic wait_grants(input string tag, input int target_count, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (gnt_seen >= target_count) begin
                ok = 1;
                break;
            end
        end
        #1;
        check({"grants_", tag}, 32'(ok), 32'(1));
    endtask

    // Single request held for one cycle, so only one window is expected
    task automatic single_req(input string tag, input logic id,
                              input logic [WIDTH-1:0] start, input logic [WIDTH-1:0] len);
        if (id) begin bus.START1 = start; bus.LEN1 = len; end
        else    begin bus.START0 = start; bus.LEN0 = len; end
        exp_q.push_back('{id: id, start: start, len: len});
        bus.REQ = onehot(id);
        @(posedge clk); #1;
        bus.REQ = 2'b00;
        wait_idle(tag, 400);
    endtask

    initial begin
        int base;
        reset      = 1'b1;
        bus.REQ    = 2'b00;
        bus.START0 = '0;
        bus.START1 = '0;
        bus.LEN0   = '0;
        bus.LEN1   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",   32'(bus.GNT),       32'(0));
        check("rst_done",  32'(bus.DONE),      32'(0));
        check("rst_busy",  32'(bus.BUSY),      32'(0));
        check("rst_load",  32'(bus.CNT_LOAD),  32'(0));
        check("rst_value", 32'(bus.CNT_VALUE), 32'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic window, wrap-around and zero length (pointer ends favouring 0)
        single_req("single", 1'b0, 8'h10, 8'd3);
        single_req("wrap",   1'b0, 8'hF0, 8'h20);
        single_req("len0",   1'b1, 8'h55, 8'd0);

        // Contention: both held, grants alternate starting with requester 0
        bus.START0 = 8'h20; bus.LEN0 = 8'd2;
        bus.START1 = 8'h40; bus.LEN1 = 8'd2;
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{id: logic'(i % 2), start: (i % 2) ? 8'h40 : 8'h20, len: 8'd2});
        base = gnt_seen;
        bus.REQ = 2'b11;
        wait_grants("rr", base + 4, 100);
        bus.REQ = 2'b00;
        wait_idle("rr", 100);

        // Withdrawn request and mid-window noise on REQ and START/LEN
        bus.START1 = 8'h00; bus.LEN1 = 8'd10;
        exp_q.push_back('{id: 1'b1, start: 8'h00, len: 8'd10});
        bus.REQ = 2'b10;
        @(posedge clk); #1;
        bus.REQ = 2'b00; bus.START1 = 8'h77; bus.LEN1 = 8'd1;
        @(posedge clk); #1;
        bus.REQ = 2'b01;
        @(posedge clk); #1;
        bus.REQ = 2'b10;
        @(posedge clk); #1;
        bus.REQ = 2'b00;
        @(posedge clk); #1;
        bus.REQ = 2'b10;
        @(posedge clk); #1;
        bus.REQ = 2'b00;
        wait_idle("noise", 100);
        repeat (4) @(posedge clk);
        #1;
        check("noise_idle_busy", 32'(bus.BUSY), 32'(0));
        check("noise_idle_gnt",  32'(bus.GNT),  32'(0));

        // Reset in RUN aborts the window; pointer returns to requester 0
        bus.START0 = 8'h30; bus.LEN0 = 8'd20;
        exp_q.push_back('{id: 1'b0, start: 8'h30, len: 8'd20});
        bus.REQ = 2'b01;
        @(posedge clk); #1;
        bus.REQ = 2'b00;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_gnt",  32'(bus.GNT),      32'(0));
        check("mid_rst_done", 32'(bus.DONE),     32'(0));
        check("mid_rst_busy", 32'(bus.BUSY),     32'(0));
        check("mid_rst_load", 32'(bus.CNT_LOAD), 32'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(bus.DONE), 32'(0));
        end
        @(posedge clk); #1;
        bus.START0 = 8'h01; bus.LEN0 = 8'd1;
        bus.START1 = 8'h02; bus.LEN1 = 8'd1;
        exp_q.push_back('{id: 1'b0, start: 8'h01, len: 8'd1});
        exp_q.push_back('{id: 1'b1, start: 8'h02, len: 8'd1});
        base = gnt_seen;
        bus.REQ = 2'b11;
        wait_grants("post_rst", base + 2, 100);
        bus.REQ = 2'b00;
        wait_idle("post_rst", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a bounded wait is itself stuck
    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares one loadable up-counter between two requesters. Each requester asks for a counting window by supplying a start value and a length. The arbiter loads the counter with the start value, watches the count, and signals completion when the count reaches start+length. It drives the counter's LOAD/VALUE inputs and observes its C output; the counter's own CLK/RESET are tied to the same CLK/RESET.

## Interface

- WIDTH, 8, counter/value width in bits

- CLK  input  1  rising-edge clock, shared with the counter
- RESET  input  1  reset RESET, asynchronous, active-high; clock CLK
- REQ  input  2  per-requester request level; REQ[i] for requester i
- START0, START1  input  WIDTH  start value for requester 0 / 1
- LEN0, LEN1  input  WIDTH  window length for requester 0 / 1 (counts beyond start)
- GNT  output  2  one-hot grant, held for the whole window
- DONE  output  2  one-cycle completion pulse to the granted requester
- BUSY  output  1  high whenever the state is not IDLE
- CNT_LOAD  output  1  to counter LOAD
- CNT_VALUE  output  WIDTH  to counter VALUE
- CNT_C  input  WIDTH  from counter C

## Operation

- States: IDLE, LOAD, RUN. All outputs are registered.
- Reset values: GNT=0, DONE=0, BUSY=0, CNT_LOAD=0, CNT_VALUE=0, state=IDLE, round-robin pointer favours requester 0.
- IDLE:
  - If any REQ bit is high, grant one requester.
  - With only one request, grant it.
  - With both requesting, grant the requester favoured by the pointer.
  - After each grant, the pointer moves to the other requester.
- On the grant edge:
  - Set GNT[i]=1, CNT_LOAD=1, CNT_VALUE=STARTi.
  - Capture target = STARTi + LENi, modulo 2^WIDTH, with the carry discarded.
  - Go to LOAD.
- LOAD: lasts exactly one cycle. CNT_LOAD clears at the next edge; go to RUN. CNT_C is ignored in LOAD because it is stale.
- RUN:
  - Compare CNT_C == target every cycle.
  - On a match, at the next edge: GNT=0, DONE[i]=1 for one cycle, go to IDLE.
- CNT_VALUE holds its last value after the window; it is don't-care while CNT_LOAD=0.
- Handshake rules:
  - A requester holds STARTi/LENi stable while REQ[i]=1 and until GNT[i] rises.
  - Inputs are sampled only on the grant edge.
  - Dropping REQ before the grant withdraws the request; no grant is issued.
  - REQ changes during LOAD/RUN have no effect on the current window.
  - If REQ[i] is still high when DONE[i] pulses, it counts as a new request in IDLE and competes under round-robin.
- Wrap-around: the counter wraps naturally, and target is computed modulo 2^WIDTH. Example: START=0xF0, LEN=0x20 gives target=0x10.
- LEN=0: target equals START, so the match occurs on the first RUN cycle.
- RESET mid-window: all outputs return to reset values immediately (asynchronously). No DONE is issued for the aborted window, and the pointer resets to requester 0.

## Timing

- Edge k: grant is taken in IDLE; GNT, CNT_LOAD and CNT_VALUE become valid after k.
- Edge k+1: counter loads START; CNT_LOAD falls; state becomes RUN. CNT_C=START.
- Edge k+1+L: CNT_C=START+L, matching target.
- Edge k+2+L: DONE[i]=1, GNT=0, state=IDLE.
- Window duration: GNT is high for L+2 cycles.
- DONE width: exactly 1 cycle.
- Back-to-back windows: the earliest next grant edge is k+3+L, so there is one IDLE cycle between windows.
- BUSY is high from edge k to edge k+2+L, coincident with GNT.

## Test plan

- Single request: REQ=01, START0=0x10, LEN0=3 -> GNT=01 for 5 cycles; CNT_LOAD high 1 cycle with CNT_VALUE=0x10; DONE=01 one cycle when the cycle before showed CNT_C=0x13.
- LEN=0: REQ=10, START1=0x55, LEN1=0 -> DONE[1] pulses at edge k+2; GNT high 2 cycles.
- Wrap: START0=0xF0, LEN0=0x20 -> counter passes 0xFF->0x00; DONE when CNT_C=0x10 is observed, 0x22 cycles after grant.
- Contention and fairness: REQ=11 held continuously, LEN0=LEN1=2 -> grants alternate 01,10,01,10. The first grant goes to requester 0, with one IDLE cycle between windows.
- Withdrawn request and in-window noise: REQ0 pulses 1 cycle while requester 1 is running -> requester 0 is not granted if REQ0 is low again by IDLE; toggling REQ1 mid-window leaves GNT/DONE unchanged.
- Reset mid-window: assert RESET during RUN -> GNT, DONE, BUSY, CNT_LOAD drop immediately; no DONE pulse; after release, REQ=11 grants requester 0 first.
